// File: rtl/conv_win3x3_gen.sv
// conv_win3x3_gen: raster 3x3 neighbourhood generator (two line buffers, latency-1 window strobe).
// Borders replicate by default; define CONV_WIN_ZERO_PAD_EN to zero out-of-image neighbours instead.
module conv_win3x3_gen #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic [7:0] pix_in,
  input  logic       pix_valid,
  output logic       in_ready,
  output logic [7:0] win_center,
  output logic [7:0] win_up,
  output logic [7:0] win_left,
  output logic [7:0] win_right,
  output logic [7:0] win_down,
  output logic [7:0] win_ul,
  output logic [7:0] win_ur,
  output logic [7:0] win_dl,
  output logic [7:0] win_dr,
  output logic       win_valid
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = $clog2(IMG_H + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_ZERO = CW'(0);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_ZERO = RW'(0);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic [RW-1:0] ROW_END  = RW'(IMG_H);
`ifdef CONV_WIN_ZERO_PAD_EN
  localparam logic [7:0] REP_MASK = 8'h00;
`else
  localparam logic [7:0] REP_MASK = 8'hFF;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2, FLUSH = 2'd3} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          edge_q, edge_d;
  logic          in_ready_q, in_ready_d;
  logic [23:0]   s1_q, s1_d, s2_q, s2_d;
  logic [71:0]   win_q, win_d;
  logic          win_valid_q, win_valid_d;
  logic [7:0]    lb1_q [IMG_W];
  logic [7:0]    lb2_q [IMG_W];

  logic          accept_s, flush_s, prefetch_s, beat_win_s, shift_s;
  logic [CW-1:0] rd_addr_s;
  logic [23:0]   new_col_s;
  logic          up_oob_s, down_oob_s, left_oob_s, right_oob_s;
  logic [7:0]    ct_s, cm_s, cb_s, lt_s, lm_s, lb_s, rt_s, rm_s, rb_s;

  function automatic logic [7:0] pad(input logic oob, input logic [7:0] rep, input logic [7:0] val);
    pad = oob ? (rep & REP_MASK) : val;
  endfunction

  // Column shift pipeline: s1 holds column c-1, s2 column c-2, new_col is column c ({top,mid,bot}).
  always_comb begin
    accept_s   = pix_valid && in_ready_q && !frame_start;
    flush_s    = (state_q == FLUSH) && !frame_start;
    prefetch_s = (state_q == RUN) && (row_q == ROW_END) && !frame_start;
    beat_win_s = accept_s && (row_q != ROW_ZERO) && (col_q != COL_ZERO);
    shift_s    = accept_s || prefetch_s || flush_s;
    if (flush_s && (col_q != COL_LAST)) begin
      rd_addr_s = col_q + COL_ONE;
    end else begin
      rd_addr_s = col_q;
    end
    new_col_s = {lb2_q[rd_addr_s], lb1_q[rd_addr_s], pix_in};
    if (shift_s) begin
      s1_d = new_col_s;
      s2_d = s1_q;
    end else begin
      s1_d = s1_q;
      s2_d = s2_q;
    end
  end

  // Border flags and 3x3 assembly for whichever trigger fires this cycle.
  always_comb begin
    if (flush_s) begin
      up_oob_s    = 1'b0;
      down_oob_s  = 1'b1;
      left_oob_s  = (col_q == COL_ZERO);
      right_oob_s = (col_q == COL_LAST);
    end else if (edge_q) begin
      up_oob_s    = (row_q == ROW_TWO);
      down_oob_s  = 1'b0;
      left_oob_s  = 1'b0;
      right_oob_s = 1'b1;
    end else begin
      up_oob_s    = (row_q == ROW_ONE);
      down_oob_s  = 1'b0;
      left_oob_s  = (col_q == COL_ONE);
      right_oob_s = 1'b0;
    end
    {ct_s, cm_s, cb_s} = s1_q;
    lt_s = pad(left_oob_s, ct_s, s2_q[23:16]);
    lm_s = pad(left_oob_s, cm_s, s2_q[15:8]);
    lb_s = pad(left_oob_s, cb_s, s2_q[7:0]);
    rt_s = pad(right_oob_s, ct_s, new_col_s[23:16]);
    rm_s = pad(right_oob_s, cm_s, new_col_s[15:8]);
    rb_s = pad(right_oob_s, cb_s, new_col_s[7:0]);
    win_valid_d = !frame_start && (beat_win_s || edge_q || flush_s);
    if (win_valid_d) begin
      win_d = {cm_s, pad(up_oob_s, cm_s, ct_s), lm_s, rm_s, pad(down_oob_s, cm_s, cb_s),
               pad(up_oob_s, lm_s, lt_s), pad(up_oob_s, rm_s, rt_s),
               pad(down_oob_s, lm_s, lb_s), pad(down_oob_s, rm_s, rb_s)};
    end else begin
      win_d = win_q;
    end
  end

  // Column/row counters and the edge-slot request raised by the last beat of rows 1..IMG_H-1.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    edge_d = accept_s && (row_q != ROW_ZERO) && (col_q == COL_LAST);
    if (frame_start) begin
      col_d = COL_ZERO;
      row_d = ROW_ZERO;
    end else if (accept_s || flush_s) begin
      if (col_q == COL_LAST) begin
        col_d = COL_ZERO;
        row_d = flush_s ? ROW_ZERO : row_q + ROW_ONE;
      end else begin
        col_d = col_q + COL_ONE;
      end
    end else begin
      col_d = col_q;
    end
  end

  // Next-state logic; RUN lingers one cycle past the final beat to issue its edge slot.
  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      state_d = FILL;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        FILL:    state_d = (accept_s && (col_q == COL_LAST)) ? RUN : FILL;
        RUN:     state_d = (row_q == ROW_END) ? FLUSH : RUN;
        FLUSH:   state_d = (col_q == COL_LAST) ? IDLE : FLUSH;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output decode: ready only while a frame still has beats to take.
  always_comb begin
    in_ready_d = ((state_d == FILL) || (state_d == RUN)) && (row_d != ROW_END);
  end

  // State, counters, pipeline and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_q       <= COL_ZERO;
      row_q       <= ROW_ZERO;
      edge_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      s1_q        <= 24'h000000;
      s2_q        <= 24'h000000;
      win_q       <= 72'h0;
      win_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      edge_q      <= edge_d;
      in_ready_q  <= in_ready_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
    end
  end

  // Line buffers rotate per column: row r-1 moves to the r-2 buffer as row r is written.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      lb1_q[col_q] <= pix_in;
      lb2_q[col_q] <= lb1_q[col_q];
    end
  end

  assign in_ready   = in_ready_q;
  assign win_valid  = win_valid_q;
  assign win_center = win_q[71:64];
  assign win_up     = win_q[63:56];
  assign win_left   = win_q[55:48];
  assign win_right  = win_q[47:40];
  assign win_down   = win_q[39:32];
  assign win_ul     = win_q[31:24];
  assign win_ur     = win_q[23:16];
  assign win_dl     = win_q[15:8];
  assign win_dr     = win_q[7:0];
endmodule

// File: tb/tb_conv_win3x3_gen.sv
// Bench for conv_win3x3_gen: frames of random/patterned pixels checked against a clamp-based window model.
module tb_conv_win3x3_gen;
  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rst_n, frame_start, pix_valid;
  logic [7:0] pix_in;
  logic       in_ready, win_valid;
  logic [7:0] win_center, win_up, win_left, win_right, win_down, win_ul, win_ur, win_dl, win_dr;
  wire  [71:0] obs_w = {win_center, win_up, win_left, win_right, win_down, win_ul, win_ur, win_dl, win_dr};

  always #5 clk = ~clk;

  conv_win3x3_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_in(pix_in), .pix_valid(pix_valid),
    .in_ready(in_ready), .win_center(win_center), .win_up(win_up), .win_left(win_left),
    .win_right(win_right), .win_down(win_down), .win_ul(win_ul), .win_ur(win_ur),
    .win_dl(win_dl), .win_dr(win_dr), .win_valid(win_valid)
  );

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          nobs = 0;
  int          last_win_cyc = 0;
  logic [71:0] exp_q [$];
  logic [71:0] obs [N];
  logic [7:0]  img [H][W];

`ifdef CONV_WIN_ZERO_PAD_EN
  localparam logic [71:0] WIN_00 = 72'h00_00_00_01_0a_00_00_00_0b;
  localparam logic [71:0] WIN_13 = 72'h0d_03_0c_00_17_02_00_16_00;
  localparam logic [71:0] WIN_20 = 72'h14_0a_00_15_00_00_0b_00_00;
`else
  localparam logic [71:0] WIN_00 = 72'h00_00_00_01_0a_00_01_0a_0b;
  localparam logic [71:0] WIN_13 = 72'h0d_03_0c_0d_17_02_03_16_17;
  localparam logic [71:0] WIN_20 = 72'h14_0a_14_15_14_0a_0b_14_15;
`endif

  function automatic logic [7:0] px(input int r, input int c);
    int rr, cc;
    rr = r;
    cc = c;
`ifdef CONV_WIN_ZERO_PAD_EN
    if (rr < 0 || rr >= H || cc < 0 || cc >= W) return 8'h00;
`else
    if (rr < 0) rr = 0;
    if (rr >= H) rr = H - 1;
    if (cc < 0) cc = 0;
    if (cc >= W) cc = W - 1;
`endif
    return img[rr][cc];
  endfunction

  function automatic logic [71:0] win_of(input int r, input int c);
    return {px(r, c), px(r - 1, c), px(r, c - 1), px(r, c + 1), px(r + 1, c),
            px(r - 1, c - 1), px(r - 1, c + 1), px(r + 1, c - 1), px(r + 1, c + 1)};
  endfunction

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] expv);
    checks++;
    assert (got === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, expv);
    end
  endtask

  task automatic sample();
    logic [71:0] e;
    if (win_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_win_valid", {71'b0, win_valid}, 72'd0);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("window_%0d", nobs), obs_w, e);
        if (nobs < N) obs[nobs] = obs_w;
        nobs++;
        last_win_cyc = cyc;
      end
    end
  endtask

  task automatic run_frame(input int gap_pct, input int abort_at, input bit rst_flush, input bit pat);
    int idx, last_beat_cyc;
    bit drv_acc, v, ended;
    idx = 0; drv_acc = 1'b0; ended = 1'b0; last_beat_cyc = 0;
    @(negedge clk); cyc++;
    sample();
    exp_q.delete();
    nobs = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = pat ? 8'(10 * r + c) : 8'($urandom);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        exp_q.push_back(win_of(r, c));
    frame_start = 1'b1;
    pix_valid = 1'b0;
    for (int k = 0; k < 2000 && !ended; k++) begin
      @(negedge clk); cyc++;
      frame_start = 1'b0;
      sample();
      if (drv_acc) begin
        idx++;
        if (idx == N) last_beat_cyc = cyc;
      end
      if (idx == N) chk("in_ready_low_after_last_beat", {71'b0, in_ready}, 72'd0);
      if (abort_at >= 0 && idx == abort_at) begin
        pix_valid = 1'b0;
        ended = 1'b1;
      end else if (rst_flush && idx == N && exp_q.size() == 2) begin
        pix_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_reset_window", obs_w, 72'd0);
        chk("async_reset_flags", {70'b0, win_valid, in_ready}, 72'd0);
        ended = 1'b1;
      end else if (idx == N && exp_q.size() == 0) begin
        pix_valid = 1'b0;
        ended = 1'b1;
        chk("window_count", 72'(nobs), 72'(N));
        chk("edge_to_last_flush_latency", 72'(last_win_cyc - last_beat_cyc), 72'(W + 1));
        if (pat) begin
          chk("window_centre_0_0", obs[0], WIN_00);
          chk("edge_window_centre_1_3", obs[7], WIN_13);
          chk("flush_window_centre_2_0", obs[8], WIN_20);
        end
      end else begin
        v = (idx < N) && (int'($urandom_range(99)) >= gap_pct);
        pix_valid = v;
        pix_in = v ? img[idx / W][idx % W] : 8'($urandom);
        drv_acc = v && in_ready;
      end
    end
    if (!ended) chk("frame_timeout_pending_windows", 72'(exp_q.size()), 72'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    frame_start = 1'b0;
    pix_valid = 1'b0;
    pix_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_window", obs_w, 72'd0);
    chk("reset_flags", {70'b0, win_valid, in_ready}, 72'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_not_ready", {71'b0, in_ready}, 72'd0);

    run_frame(0, -1, 1'b0, 1'b1);
    run_frame(50, -1, 1'b0, 1'b1);
    run_frame(30, -1, 1'b0, 1'b0);
    run_frame(50, W + 2, 1'b0, 1'b0);
    run_frame(40, -1, 1'b0, 1'b0);
    run_frame(0, -1, 1'b1, 1'b0);

    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("post_reset_quiet", {70'b0, win_valid, in_ready}, 72'd0);
    end
    run_frame(35, -1, 1'b0, 1'b0);
    run_frame(0, -1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
